// File: rtl/fire_control.sv
// -----------------------------------------------------------------------------
// fire_control
//   Fire-control sequencer feeding the ammo saturation counter. Turns the pilot
//   trigger, mode selection and reload request into clean one-cycle fire/load
//   pulses carrying the decrement / load amounts, and enforces attack mode,
//   ammo sufficiency, inter-shot cooldown and (optionally) burst fire.
//
//   Optional feature macro: FIRE_CTRL_BURST_EN
//     defined   : burst count = burst_len (0 treated as 1), up to 7 shots/press
//     undefined : burst_len ignored, one shot per trigger press
//
// Ports
//   clk            system clock, rising edge
//   rst            asynchronous active-low reset
//   mode_selector  attack mode when 4'b0010
//   trigger        pilot trigger level (rising edge fires)
//   reload_req     reload request level
//   reload_amt     rounds loaded on reload
//   ammo_level     current count fed back from the ammo counter
//   shot_cost      rounds consumed per shot
//   cooldown       idle cycles between shots (0 behaves as 1)
//   burst_len      shots per trigger press (burst build only)
//   fire           one-cycle decrement pulse, fire_rate valid with it
//   load           one-cycle load pulse, ammo_load valid with it
//   error          one-cycle pulse after a rejected trigger
//   state          FSM state for debug/status
// -----------------------------------------------------------------------------
module fire_control #(
   parameter int AMMO_W = 9,
   parameter int CD_W   = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [3:0]        mode_selector,
   input  logic              trigger,
   input  logic              reload_req,
   input  logic [AMMO_W-1:0] reload_amt,
   input  logic [AMMO_W-1:0] ammo_level,
   input  logic [AMMO_W-1:0] shot_cost,
   input  logic [CD_W-1:0]   cooldown,
   input  logic [2:0]        burst_len,
   output logic              fire,
   output logic [AMMO_W-1:0] fire_rate,
   output logic              load,
   output logic [AMMO_W-1:0] ammo_load,
   output logic              error,
   output logic [1:0]        state
);

   typedef enum logic [1:0] {
      S_IDLE     = 2'b00,
      S_FIRE     = 2'b01,
      S_COOLDOWN = 2'b10,
      S_RELOAD   = 2'b11
   } state_e;

   state_e            state_q, state_d;
   logic              trig_q;
   logic              error_q, error_d;
   logic [AMMO_W-1:0] fire_rate_q, fire_rate_d;
   logic [AMMO_W-1:0] ammo_load_q, ammo_load_d;
   logic [CD_W-1:0]   cd_cnt_q, cd_cnt_d;

   logic trig_edge;
   logic attack_mode;
   logic ammo_ok;
   logic more_shots;

   assign trig_edge   = trigger & ~trig_q;
   assign attack_mode = (mode_selector == 4'b0010);
   assign ammo_ok     = (ammo_level >= shot_cost);

`ifdef FIRE_CTRL_BURST_EN
   logic [2:0] shots_left_q, shots_left_d;
   logic [2:0] burst_cnt;

   assign burst_cnt  = (burst_len == 3'd0) ? 3'd1 : burst_len;
   assign more_shots = (shots_left_q != 3'd0);
`else
   // Burst input is only consumed by the burst build.
   logic unused_burst_len;
   assign unused_burst_len = ^burst_len;
   assign more_shots       = 1'b0;
`endif

   // Next-state and registered-output logic.
   always_comb begin
      // NOTE: every variable gets a default first so no path can infer a latch.
      state_d     = state_q;
      error_d     = 1'b0;
      fire_rate_d = fire_rate_q;
      ammo_load_d = ammo_load_q;
      cd_cnt_d    = cd_cnt_q;
`ifdef FIRE_CTRL_BURST_EN
      shots_left_d = shots_left_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (reload_req) begin
               state_d     = S_RELOAD;
               ammo_load_d = reload_amt;
            end else if (trig_edge) begin
               if (!attack_mode || !ammo_ok) begin
                  error_d = 1'b1;
               end else begin
                  state_d     = S_FIRE;
                  fire_rate_d = shot_cost;
`ifdef FIRE_CTRL_BURST_EN
                  shots_left_d = burst_cnt - 3'd1;
`endif
               end
            end
         end
         S_FIRE: begin
            // A cooldown of at least one cycle lets the counter's ammo_level
            // settle before the next sufficiency check.
            state_d  = S_COOLDOWN;
            cd_cnt_d = (cooldown == '0) ? CD_W'(1) : cooldown;
         end
         S_COOLDOWN: begin
            if (cd_cnt_q <= CD_W'(1)) begin
               // Burst cut short by mode/ammo ends quietly, no error pulse.
               if (more_shots && attack_mode && ammo_ok) begin
                  state_d = S_FIRE;
`ifdef FIRE_CTRL_BURST_EN
                  shots_left_d = shots_left_q - 3'd1;
`endif
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               cd_cnt_d = cd_cnt_q - CD_W'(1);
            end
         end
         S_RELOAD: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         trig_q      <= 1'b0;
         error_q     <= 1'b0;
         fire_rate_q <= '0;
         ammo_load_q <= '0;
         cd_cnt_q    <= '0;
`ifdef FIRE_CTRL_BURST_EN
         shots_left_q <= 3'd0;
`endif
      end else begin
         // NOTE: non-blocking assignments so all registers update from the
         // same pre-edge values.
         state_q     <= state_d;
         trig_q      <= trigger;
         error_q     <= error_d;
         fire_rate_q <= fire_rate_d;
         ammo_load_q <= ammo_load_d;
         cd_cnt_q    <= cd_cnt_d;
`ifdef FIRE_CTRL_BURST_EN
         shots_left_q <= shots_left_d;
`endif
      end
   end

   // Moore outputs straight from registers: fire and load are exclusive.
   assign fire      = (state_q == S_FIRE);
   assign load      = (state_q == S_RELOAD);
   assign fire_rate = fire_rate_q;
   assign ammo_load = ammo_load_q;
   assign error     = error_q;
   assign state     = state_q;

endmodule
